// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between the three requesters, the arbiter and the memory slave.
// The arbiter takes the master modport; the requesters and memory together take the slave modport.
interface mem_bus_arbiter_if;
   logic        f_req;
   logic [15:0] f_addr;
   logic        f_ack;
   logic        f_wait;

   logic        d_req;
   logic        d_we;
   logic        d_byte;
   logic [15:0] d_addr;
   logic [15:0] d_wdata;
   logic        d_ack;
   logic        d_wait;

   logic        x_req;
   logic        x_we;
   logic [15:0] x_addr;
   logic [15:0] x_wdata;
   logic        x_ack;

   logic [15:0] rdata;
   logic        bus_err;
   logic [1:0]  grant;

   logic        mem_req;
   logic        mem_we;
   logic        mem_byte;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        mem_ack;

   modport master (
      input  f_req, f_addr,
      input  d_req, d_we, d_byte, d_addr, d_wdata,
      input  x_req, x_we, x_addr, x_wdata,
      input  mem_rdata, mem_ack,
      output f_ack, f_wait, d_ack, d_wait, x_ack,
      output rdata, bus_err, grant,
      output mem_req, mem_we, mem_byte, mem_addr, mem_wdata
   );

   modport slave (
      output f_req, f_addr,
      output d_req, d_we, d_byte, d_addr, d_wdata,
      output x_req, x_we, x_addr, x_wdata,
      output mem_rdata, mem_ack,
      input  f_ack, f_wait, d_ack, d_wait, x_ack,
      input  rdata, bus_err, grant,
      input  mem_req, mem_we, mem_byte, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Three-way memory port arbiter (D > F > X, X forced after STARVE_MAX losses), IDLE/ACCESS/DONE.
// Ack arrives one cycle after mem_ack (or after TIMEOUT silent cycles, with bus_err); requesters stall on *_wait.
module mem_bus_arbiter #(
   parameter int unsigned  STARVE_MAX = 8,
   parameter int unsigned  TIMEOUT    = 64,
   parameter logic [15:0]  ERR_DATA   = 16'hFFFF
) (
   input logic               clk,
   input logic               rst,
   mem_bus_arbiter_if.master bus
);
   localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);
   localparam int unsigned TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [1:0] G_NONE = 2'd0;
   localparam logic [1:0] G_F    = 2'd1;
   localparam logic [1:0] G_D    = 2'd2;
   localparam logic [1:0] G_X    = 2'd3;

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

   state_t              r_state;
   logic [1:0]          r_grant;
   logic                r_f_ack;
   logic                r_d_ack;
   logic                r_x_ack;
   logic [15:0]         r_rdata;
   logic                r_bus_err;
   logic                r_mem_req;
   logic                r_mem_we;
   logic                r_mem_byte;
   logic [15:0]         r_mem_addr;
   logic [15:0]         r_mem_wdata;
   logic [STARVE_W-1:0] r_starve;
   logic [TMO_W-1:0]    r_tmo;

   logic                w_x_forced;
   logic [1:0]          w_win;

   assign w_x_forced = bus.x_req && (r_starve == STARVE_W'(STARVE_MAX));

   always_comb begin
      w_win = G_NONE;
      if (w_x_forced)     w_win = G_X;
      else if (bus.d_req) w_win = G_D;
      else if (bus.f_req) w_win = G_F;
      else if (bus.x_req) w_win = G_X;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_grant     <= G_NONE;
         r_f_ack     <= 1'b0;
         r_d_ack     <= 1'b0;
         r_x_ack     <= 1'b0;
         r_rdata     <= 16'h0000;
         r_bus_err   <= 1'b0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_byte  <= 1'b0;
         r_mem_addr  <= 16'h0000;
         r_mem_wdata <= 16'h0000;
         r_starve    <= '0;
         r_tmo       <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_win != G_NONE) begin
                  r_grant   <= w_win;
                  r_mem_req <= 1'b1;
                  r_tmo     <= '0;
                  r_state   <= S_ACCESS;
                  case (w_win)
                     G_F: begin
                        r_mem_addr  <= bus.f_addr;
                        r_mem_we    <= 1'b0;
                        r_mem_byte  <= 1'b0;
                        r_mem_wdata <= 16'h0000;
                     end
                     G_D: begin
                        r_mem_addr  <= bus.d_addr;
                        r_mem_we    <= bus.d_we;
                        r_mem_byte  <= bus.d_byte;
                        r_mem_wdata <= bus.d_wdata;
                     end
                     default: begin
                        r_mem_addr  <= bus.x_addr;
                        r_mem_we    <= bus.x_we;
                        r_mem_byte  <= 1'b0;
                        r_mem_wdata <= bus.x_wdata;
                     end
                  endcase
                  // Only a pending X that loses counts towards forcing it through.
                  if (bus.x_req && (w_win != G_X)) begin
                     if (r_starve != STARVE_W'(STARVE_MAX))
                        r_starve <= r_starve + 1'b1;
                  end else begin
                     r_starve <= '0;
                  end
               end else begin
                  r_grant <= G_NONE;
               end
            end
            S_ACCESS: begin
               // A late mem_ack landing on the timeout cycle still counts as success.
               if (bus.mem_ack || (r_tmo == TMO_W'(TIMEOUT - 1))) begin
                  r_mem_req <= 1'b0;
                  r_f_ack   <= (r_grant == G_F);
                  r_d_ack   <= (r_grant == G_D);
                  r_x_ack   <= (r_grant == G_X);
                  r_state   <= S_DONE;
                  if (bus.mem_ack) begin
                     r_rdata   <= bus.mem_rdata;
                     r_bus_err <= 1'b0;
                  end else begin
                     r_rdata   <= ERR_DATA;
                     r_bus_err <= 1'b1;
                  end
               end else begin
                  r_tmo <= r_tmo + 1'b1;
               end
            end
            S_DONE: begin
               r_f_ack   <= 1'b0;
               r_d_ack   <= 1'b0;
               r_x_ack   <= 1'b0;
               r_bus_err <= 1'b0;
               r_grant   <= G_NONE;
               r_state   <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.f_ack     = r_f_ack;
   assign bus.d_ack     = r_d_ack;
   assign bus.x_ack     = r_x_ack;
   assign bus.f_wait    = bus.f_req & ~r_f_ack;
   assign bus.d_wait    = bus.d_req & ~r_d_ack;
   assign bus.rdata     = r_rdata;
   assign bus.bus_err   = r_bus_err;
   assign bus.grant     = r_grant;
   assign bus.mem_req   = r_mem_req;
   assign bus.mem_we    = r_mem_we;
   assign bus.mem_byte  = r_mem_byte;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: vector table, directed corner sequences, then random traffic
// against a transaction-level model (priority + starvation count, memory latency vs timeout).
module tb_mem_bus_arbiter;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_bus_arbiter_if bus();

   mem_bus_arbiter #(.STARVE_MAX(8), .TIMEOUT(64), .ERR_DATA(16'hFFFF)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          n_tests = 0;
   int          n_fail  = 0;
   int          resp_lat = 1;
   logic [15:0] resp_data = 16'h0000;
   logic        resp_en = 1'b1;
   logic        manual_ack = 1'b0;
   int          resp_cnt = 0;
   logic        resp_done = 1'b0;

   // Memory slave: acks in the resp_lat-th cycle that mem_req is high.
   always @(posedge clk) begin
      #1;
      bus.mem_ack = 1'b0;
      if (manual_ack) begin
         bus.mem_ack   = 1'b1;
         bus.mem_rdata = resp_data;
      end else if (bus.mem_req && !resp_done) begin
         resp_cnt++;
         if (resp_en && resp_cnt == resp_lat) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = resp_data;
            resp_done     = 1'b1;
         end
      end else if (!bus.mem_req) begin
         resp_cnt  = 0;
         resp_done = 1'b0;
      end
   end

   typedef struct {
      logic f, d, x, dwe, dbyte, xwe;
      logic [15:0] faddr, daddr, dwd, xaddr, xwd;
      int lat;
      logic [15:0] rd;
      logic [1:0] eg;
      logic [15:0] eaddr;
      logic ewe, ebyte;
      logic [15:0] ewd;
   } vec_t;

   vec_t vt[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [2:0] onehot(input logic [1:0] g);
      case (g)
         2'd1:    return 3'b001;
         2'd2:    return 3'b010;
         2'd3:    return 3'b100;
         default: return 3'b000;
      endcase
   endfunction

   task automatic clr_reqs();
      bus.f_req = 0; bus.f_addr = 0;
      bus.d_req = 0; bus.d_we = 0; bus.d_byte = 0; bus.d_addr = 0; bus.d_wdata = 0;
      bus.x_req = 0; bus.x_we = 0; bus.x_addr = 0; bus.x_wdata = 0;
   endtask

   task automatic wait_ack(input string name, output int cyc, output logic [2:0] acks);
      cyc  = 0;
      acks = 3'b000;
      while (cyc < 200) begin
         @(negedge clk);
         cyc++;
         acks = {bus.x_ack, bus.d_ack, bus.f_ack};
         if (acks != 3'b000) break;
      end
      chk({name, "_ack_seen"}, 32'(acks != 3'b000), 1);
   endtask

   task automatic run_until_drop(output int cnt);
      cnt = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!bus.mem_req) break;
         cnt++;
      end
   endtask

   initial begin
      int          cyc, cnt;
      logic [2:0]  acks;
      int          m_starve, m_lat, acc, ntx, cycles, pick;
      logic        busy, prev_req, m_we, pf, pd, px;
      logic [1:0]  m_grant, eg;

      clr_reqs();
      bus.mem_ack = 0;
      bus.mem_rdata = 0;

      // Reset with every requester asserted.
      rst = 0;
      bus.f_req = 1; bus.f_addr = 16'h0A00;
      bus.d_req = 1; bus.d_addr = 16'h0A0A;
      bus.x_req = 1; bus.x_addr = 16'h0AAA;
      repeat (2) @(negedge clk);
      chk("rst_mem_req", bus.mem_req, 0);
      chk("rst_grant", bus.grant, 0);
      chk("rst_acks", {bus.x_ack, bus.d_ack, bus.f_ack}, 0);
      chk("rst_bus_err", bus.bus_err, 0);
      chk("rst_rdata", bus.rdata, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      rst = 1;
      @(negedge clk);
      chk("rst_first_grant", bus.grant, 2);
      chk("rst_first_addr", bus.mem_addr, 16'h0A0A);
      wait_ack("rst", cyc, acks);
      chk("rst_first_ack", acks, 3'b010);
      clr_reqs();
      @(negedge clk);

      // Order: f,d,x,dwe,dbyte,xwe, faddr,daddr,dwd,xaddr,xwd, lat,rd, eg,eaddr,ewe,ebyte,ewd
      vt[0] = '{1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0, 16'h0100,16'h0000,16'h0000,16'h0000,16'h0000, 2,16'hBEEF, 2'd1,16'h0100,1'b0,1'b0,16'h0000};
      vt[1] = '{1'b0,1'b1,1'b0, 1'b0,1'b1,1'b0, 16'h0000,16'h2001,16'h0000,16'h0000,16'h0000, 1,16'h00A5, 2'd2,16'h2001,1'b0,1'b1,16'h0000};
      vt[2] = '{1'b1,1'b1,1'b0, 1'b1,1'b0,1'b0, 16'h0104,16'h2000,16'h1234,16'h0000,16'h0000, 3,16'h0000, 2'd2,16'h2000,1'b1,1'b0,16'h1234};
      vt[3] = '{1'b0,1'b0,1'b1, 1'b0,1'b0,1'b1, 16'h0000,16'h0000,16'h0000,16'h3000,16'h5555, 1,16'h0000, 2'd3,16'h3000,1'b1,1'b0,16'h5555};
      vt[4] = '{1'b1,1'b1,1'b1, 1'b0,1'b1,1'b0, 16'h0108,16'h2100,16'h0000,16'h3100,16'h0000, 2,16'h7E57, 2'd2,16'h2100,1'b0,1'b1,16'h0000};
      vt[5] = '{1'b1,1'b0,1'b1, 1'b0,1'b0,1'b0, 16'h010C,16'h0000,16'h0000,16'h3200,16'h0000, 1,16'hC0DE, 2'd1,16'h010C,1'b0,1'b0,16'h0000};
      vt[6] = '{1'b0,1'b0,1'b1, 1'b0,1'b1,1'b0, 16'h0000,16'h0000,16'h0000,16'h3300,16'h9999, 4,16'h1357, 2'd3,16'h3300,1'b0,1'b0,16'h0000};

      for (int i = 0; i < 7; i++) begin
         resp_lat  = vt[i].lat;
         resp_data = vt[i].rd;
         bus.f_req = vt[i].f; bus.f_addr = vt[i].faddr;
         bus.d_req = vt[i].d; bus.d_we = vt[i].dwe; bus.d_byte = vt[i].dbyte;
         bus.d_addr = vt[i].daddr; bus.d_wdata = vt[i].dwd;
         bus.x_req = vt[i].x; bus.x_we = vt[i].xwe;
         bus.x_addr = vt[i].xaddr; bus.x_wdata = vt[i].xwd;
         @(negedge clk);
         chk($sformatf("vec%0d_grant", i), bus.grant, vt[i].eg);
         chk($sformatf("vec%0d_mem_req", i), bus.mem_req, 1);
         chk($sformatf("vec%0d_addr", i), bus.mem_addr, vt[i].eaddr);
         chk($sformatf("vec%0d_we", i), bus.mem_we, vt[i].ewe);
         chk($sformatf("vec%0d_byte", i), bus.mem_byte, vt[i].ebyte);
         if (vt[i].ewe) chk($sformatf("vec%0d_wdata", i), bus.mem_wdata, vt[i].ewd);
         wait_ack($sformatf("vec%0d", i), cyc, acks);
         chk($sformatf("vec%0d_acks", i), acks, onehot(vt[i].eg));
         chk($sformatf("vec%0d_latency", i), cyc, vt[i].lat);
         chk($sformatf("vec%0d_bus_err", i), bus.bus_err, 0);
         if (!vt[i].ewe) chk($sformatf("vec%0d_rdata", i), bus.rdata, vt[i].rd);
         clr_reqs();
         @(negedge clk);
         chk($sformatf("vec%0d_grant_after", i), bus.grant, 0);
         chk($sformatf("vec%0d_acks_after", i), {bus.x_ack, bus.d_ack, bus.f_ack}, 0);
      end

      // Single fetch, exact ack cycle.
      resp_lat = 2; resp_data = 16'hBEEF;
      bus.f_req = 1; bus.f_addr = 16'h0100;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (k == 1) begin
            chk("fetch_addr", bus.mem_addr, 16'h0100);
            chk("fetch_we", bus.mem_we, 0);
         end
         chk($sformatf("fetch_wait_k%0d", k), bus.f_wait, 32'(k < 3));
         chk($sformatf("fetch_ack_k%0d", k), bus.f_ack, 32'(k == 3));
         if (k == 3) begin
            chk("fetch_rdata", bus.rdata, 16'hBEEF);
            bus.f_req = 0;
         end
      end

      // F and D together: D first, F right after the DONE cycle.
      resp_lat = 1; resp_data = 16'h0000;
      bus.f_req = 1; bus.f_addr = 16'h0300;
      bus.d_req = 1; bus.d_we = 1; bus.d_addr = 16'h2000; bus.d_wdata = 16'h1234;
      @(negedge clk);
      chk("prio_grant_d", bus.grant, 2);
      chk("prio_we", bus.mem_we, 1);
      chk("prio_wdata", bus.mem_wdata, 16'h1234);
      wait_ack("prio_d", cyc, acks);
      chk("prio_d_ack", acks, 3'b010);
      bus.d_req = 0; bus.d_we = 0;
      @(negedge clk);
      chk("prio_gap_grant", bus.grant, 0);
      @(negedge clk);
      chk("prio_grant_f", bus.grant, 1);
      chk("prio_f_addr", bus.mem_addr, 16'h0300);
      wait_ack("prio_f", cyc, acks);
      chk("prio_f_ack", acks, 3'b001);
      clr_reqs();
      @(negedge clk);

      // Starvation: D and X held high; X should win every 9th arbitration.
      bus.d_req = 1; bus.d_addr = 16'h4000;
      bus.x_req = 1; bus.x_addr = 16'h5000;
      for (int i = 0; i < 18; i++) begin
         for (int w = 0; w < 10; w++) begin
            @(negedge clk);
            if (bus.mem_req) break;
         end
         chk($sformatf("starve_req_seen%0d", i), bus.mem_req, 1);
         chk($sformatf("starve_grant%0d", i), bus.grant, (i % 9 == 8) ? 3 : 2);
         wait_ack($sformatf("starve%0d", i), cyc, acks);
      end
      clr_reqs();
      @(negedge clk);

      // Timeout: no mem_ack at all.
      resp_en = 0;
      bus.f_req = 1; bus.f_addr = 16'h0700;
      run_until_drop(cnt);
      chk("tmo_access_cycles", cnt, 64);
      chk("tmo_f_ack", bus.f_ack, 1);
      chk("tmo_bus_err", bus.bus_err, 1);
      chk("tmo_rdata", bus.rdata, 16'hFFFF);
      bus.f_req = 0;
      @(negedge clk);
      chk("tmo_ack_clear", bus.f_ack, 0);
      chk("tmo_err_clear", bus.bus_err, 0);
      chk("tmo_grant_clear", bus.grant, 0);
      resp_en = 1;

      // mem_ack on the very cycle the timeout would fire.
      resp_lat = 64; resp_data = 16'h6464;
      bus.x_req = 1; bus.x_addr = 16'h0800;
      run_until_drop(cnt);
      chk("tie_access_cycles", cnt, 64);
      chk("tie_x_ack", bus.x_ack, 1);
      chk("tie_bus_err", bus.bus_err, 0);
      chk("tie_rdata", bus.rdata, 16'h6464);
      clr_reqs();
      @(negedge clk);

      // Reset during ACCESS, then a stray mem_ack.
      resp_en = 0;
      bus.f_req = 1; bus.f_addr = 16'h0900;
      repeat (2) @(negedge clk);
      chk("midrst_in_access", bus.mem_req, 1);
      rst = 0;
      clr_reqs();
      @(negedge clk);
      rst = 1;
      chk("midrst_mem_req", bus.mem_req, 0);
      resp_data = 16'hAAAA;
      manual_ack = 1;
      @(negedge clk);
      manual_ack = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("midrst_acks%0d", k), {bus.x_ack, bus.d_ack, bus.f_ack}, 0);
         chk($sformatf("midrst_rdata%0d", k), bus.rdata, 0);
         chk($sformatf("midrst_grant%0d", k), bus.grant, 0);
      end
      resp_en = 1;

      // Random traffic against a transaction-level model.
      m_starve = 0; busy = 0; prev_req = 0; ntx = 0; cycles = 0;
      m_grant = 0; m_lat = 0; m_we = 0; acc = 0;
      while (ntx < 80 && cycles < 20000) begin
         @(negedge clk);
         cycles++;
         chk("rand_waits", {bus.d_wait, bus.f_wait},
             {bus.d_req & ~bus.d_ack, bus.f_req & ~bus.f_ack});
         pf = bus.f_req; pd = bus.d_req; px = bus.x_req;
         if (bus.mem_req && !prev_req) begin
            if (px && m_starve == 8) eg = 3;
            else if (pd)             eg = 2;
            else if (pf)             eg = 1;
            else if (px)             eg = 3;
            else                     eg = 0;
            if (px && eg != 3) m_starve = (m_starve < 8) ? m_starve + 1 : 8;
            else               m_starve = 0;
            chk("rand_grant", bus.grant, eg);
            case (eg)
               2'd1: begin
                  chk("rand_f_addr", bus.mem_addr, bus.f_addr);
                  chk("rand_f_ctl", {bus.mem_we, bus.mem_byte}, 0);
                  m_we = 0;
               end
               2'd2: begin
                  chk("rand_d_addr", bus.mem_addr, bus.d_addr);
                  chk("rand_d_ctl", {bus.mem_we, bus.mem_byte}, {bus.d_we, bus.d_byte});
                  if (bus.d_we) chk("rand_d_wdata", bus.mem_wdata, bus.d_wdata);
                  m_we = bus.d_we;
               end
               default: begin
                  chk("rand_x_addr", bus.mem_addr, bus.x_addr);
                  chk("rand_x_ctl", {bus.mem_we, bus.mem_byte}, {bus.x_we, 1'b0});
                  if (bus.x_we) chk("rand_x_wdata", bus.mem_wdata, bus.x_wdata);
                  m_we = bus.x_we;
               end
            endcase
            busy = 1; m_grant = eg; m_lat = resp_lat; m_data_hold = resp_data; acc = 0;
         end
         if (bus.mem_req) acc++;
         acks = {bus.x_ack, bus.d_ack, bus.f_ack};
         chk("rand_acks", acks, busy ? ((acks != 0) ? onehot(m_grant) : 3'b000) : 3'b000);
         if (acks != 0 && busy) begin
            chk("rand_latency", acc, (m_lat <= 64) ? m_lat : 64);
            chk("rand_bus_err", bus.bus_err, 32'(m_lat > 64));
            if (m_lat > 64)  chk("rand_err_rdata", bus.rdata, 16'hFFFF);
            else if (!m_we) chk("rand_rdata", bus.rdata, m_data_hold);
            busy = 0;
            ntx++;
         end
         prev_req = bus.mem_req;
         if (!bus.mem_req) begin
            pick = $urandom_range(0, 19);
            resp_lat  = (pick == 0) ? 70 : (pick == 1) ? 64 : 1 + (pick % 4);
            resp_data = 16'($urandom);
         end
         if (acks[0]) bus.f_req = 0;
         else if (!bus.f_req && $urandom_range(0, 3) == 0) begin
            bus.f_req = 1; bus.f_addr = 16'($urandom);
         end
         if (acks[1]) bus.d_req = 0;
         else if (!bus.d_req && $urandom_range(0, 3) == 0) begin
            bus.d_req = 1; bus.d_we = 1'($urandom); bus.d_byte = 1'($urandom);
            bus.d_addr = 16'($urandom); bus.d_wdata = 16'($urandom);
         end
         if (acks[2]) bus.x_req = 0;
         else if (!bus.x_req && $urandom_range(0, 3) == 0) begin
            bus.x_req = 1; bus.x_we = 1'($urandom);
            bus.x_addr = 16'($urandom); bus.x_wdata = 16'($urandom);
         end
      end
      chk("rand_completed", 32'(ntx >= 80), 1);
      clr_reqs();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   logic [15:0] m_data_hold = 16'h0000;
endmodule
